imem_dmem_arbiter: RTL
======================

// Module: imem_dmem_arbiter
// PURPOSE
//  Shares one single-ported memory between instruction fetch and the execute-stage load/store port.
//  Holds one outstanding transaction at a time, and drives fetch_stall / d_stall back to the pipeline.
//  Drops fetch responses that a pipeline flush has made stale.
//  Default priority is data over fetch; a bounded streak counter prevents fetch starvation.
// PARAMETERS
//  ADDR_W        32  address width, both ports and memory
//  DATA_W        32  data width; byte enables are DATA_W/8 bits
//  MAX_D_STREAK  4   max consecutive data grants while i_req is pending; fetch wins the next arbitration
// PORTS
//  clk      in   1         clock, rising edge
//  rst      in   1         reset, synchronous, active-high
//  i_req    in   1         fetch wants the instruction at i_addr
//  i_addr   in   ADDR_W    fetch address (PC_f)
//  flush    in   1         redirect: in-flight or granted fetch is stale
//  i_rdata  out  DATA_W    instruction word
//  i_valid  out  1         1-cycle pulse: i_rdata is valid for the current i_addr
//  fetch_stall out 1       i_req & ~i_valid
//  d_req    in   1         load/store request
//  d_we     in   1         1 = store
//  d_addr   in   ADDR_W    data address
//  d_wdata  in   DATA_W    store data
//  d_be     in   DATA_W/8  byte enables
//  d_rdata  out  DATA_W    load data
//  d_valid  out  1         1-cycle pulse: data transaction complete
//  d_stall  out  1         d_req & ~d_valid
//  m_req    out  1         memory request
//  m_we/m_addr/m_wdata/m_be out  memory command, registered
//  m_ready  in   1         memory accepts the command this cycle
//  m_rvalid in   1         response, exactly one per accepted command (reads and writes)
//  m_rdata  in   DATA_W    read data
// BEHAVIOUR
//  Reset: state=IDLE; m_req=0; m_we=0; m_addr/m_wdata/m_be=0; i_valid=0; d_valid=0; discard=0; streak=0.
//  FSM states: IDLE, REQ_I, REQ_D, RSP_I, RSP_D.
//   IDLE:  arbitrate, then load the command registers.
//          d_req & (streak<MAX_D_STREAK | ~i_req) -> REQ_D.
//          Otherwise i_req & ~flush -> REQ_I.
//          Otherwise stay in IDLE.
//   REQ_x: m_req=1; command held stable until m_ready; m_ready -> RSP_x.
//   RSP_x: wait for m_rvalid, then -> IDLE. The next grant comes one cycle later (no back-to-back issue).
//  Minimum latency is 3 cycles, from request seen in IDLE to the valid pulse (for m_ready and m_rvalid at the earliest).
//  Completion: on m_rvalid in RSP_D, register d_valid=1 and d_rdata=m_rdata.
//   In RSP_I, do the same with i_valid/i_rdata unless discard is set or flush is asserted that cycle.
//  Flush:
//   - In REQ_I or RSP_I: set discard; m_req is NOT withdrawn; the response is swallowed, with no i_valid.
//   - discard clears on the return to IDLE.
//   - Flush in IDLE blocks the fetch grant for that cycle only.
//   - Flush while in REQ_D or RSP_D: no effect.
//  Streak counter:
//   - Increments on each data grant while i_req=1.
//   - Clears on a fetch grant or when i_req=0.
//   - Saturates at MAX_D_STREAK.
//  m_rvalid outside RSP_x is ignored; a bench assertion flags it as a protocol error.
//  Reset mid-transaction returns to IDLE and drops m_req the next cycle. Stale responses arrive in IDLE and are ignored.
//  d_req/i_addr may change while not granted; a granted command uses the values captured at grant.
// STRUCTURE
//  Shared package (defines.svh): arb_state_t enum {IDLE,REQ_I,REQ_D,RSP_I,RSP_D}; mem_cmd_t struct {we,addr,wdata,be}.
//  One sub-module, arb_prio: combinational grant select plus the streak counter register.
//  The FSM and command/response registers stay in the top module.
// TESTING
//  1. Fetch 0x80000000, memory ready immediately, rvalid 1 cycle later:
//     -> i_valid at cycle 3, i_rdata=0x00000013, fetch_stall low that cycle.
//  2. i_req and d_req (load 0x1000) arrive in the same cycle -> data granted first, then fetch.
//     -> d_valid precedes i_valid; m_addr sequence is 0x1000, then 0x80000000.
//  3. d_req held high for 6 loads while i_req=1, MAX_D_STREAK=4 -> the 5th grant goes to fetch.
//  4. Flush in RSP_I with m_rvalid in the same cycle -> no i_valid pulse.
//     -> The next fetch of the new PC 0x80000040 completes normally.
//  5. Store 0xDEADBEEF, be=4'b0011, m_ready low for 3 cycles:
//     -> m_* fields are stable for all 3 cycles, then d_valid after rvalid.
//  6. rst asserted in RSP_D, then m_rvalid 2 cycles later -> no d_valid; all outputs at reset values.

Source files
------------

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package imem_dmem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  // Arbiter FSM: request phase holds the command, response phase waits for m_rvalid.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_I = 3'd1,
    REQ_D = 3'd2,
    RSP_I = 3'd3,
    RSP_D = 3'd4
  } arb_state_t;

  // Memory command layout at the default widths.
  typedef struct packed {
    logic                    we;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_DATA_W/8-1:0] be;
  } mem_cmd_t;

  // True while a fetch owns the memory (a flush in these states makes it stale).
  function automatic logic is_fetch_state(arb_state_t s);
    return (s == REQ_I) || (s == RSP_I);
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_arb_prio.sv
// Grant select for the shared memory: data wins by default, but a bounded
// streak of data grants while fetch is waiting hands the next slot to fetch.
module arb_prio #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  input  logic flush,
  output logic grant_i,
  output logic grant_d
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  // Grant decision plus next streak value; a flush only suppresses the fetch grant.
  always_comb begin
    grant_d  = arb_en & d_req & ((streak_q < STREAK_MAX) | ~i_req);
    grant_i  = arb_en & ~grant_d & i_req & ~flush;
    streak_d = streak_q;
    if (!i_req || grant_i) begin
      streak_d = '0;
    end else if (grant_d && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between fetch and load/store, one
// outstanding transaction at a time, dropping fetch responses made stale by flush.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                flush,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  output logic                fetch_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  arb_state_t          state_q, state_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_be_q, m_be_d;
  logic                i_valid_q, i_valid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                discard_q, discard_d;
  logic                grant_i, grant_d;

  arb_prio #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state_q == IDLE),
    .i_req  (i_req),
    .d_req  (d_req),
    .flush  (flush),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  // Next state, command capture at grant, and response completion.
  always_comb begin
    state_d   = state_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    i_valid_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_valid_d = 1'b0;
    d_rdata_d = d_rdata_q;
    discard_d = discard_q;

    // A flush while the fetch owns the memory marks its response stale;
    // the command itself is not withdrawn.
    if (flush && is_fetch_state(state_q)) begin
      discard_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (grant_d) begin
          state_d   = REQ_D;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
        end else if (grant_i) begin
          state_d   = REQ_I;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          m_be_d    = '1;
        end
      end
      REQ_I: if (m_ready) state_d = RSP_I;
      REQ_D: if (m_ready) state_d = RSP_D;
      RSP_I: begin
        if (m_rvalid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (!discard_q && !flush) begin
            i_valid_d = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end
      RSP_D: begin
        if (m_rvalid) begin
          state_d   = IDLE;
          d_valid_d = 1'b1;
          d_rdata_d = m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_valid_q <= 1'b0;
      d_rdata_q <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      i_valid_q <= i_valid_d;
      i_rdata_q <= i_rdata_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      discard_q <= discard_d;
    end
  end

  assign m_req       = (state_q == REQ_I) || (state_q == REQ_D);
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_be        = m_be_q;
  assign i_valid     = i_valid_q;
  assign i_rdata     = i_rdata_q;
  assign d_valid     = d_valid_q;
  assign d_rdata     = d_rdata_q;
  assign fetch_stall = i_req & ~i_valid_q;
  assign d_stall     = d_req & ~d_valid_q;

endmodule
